// File: rtl/sme_pkg.sv
// Shared definitions for the string-match-engine host: FSM encoding,
// ASCII constants used by matcher patterns, and default buffer depths.
// No logic; imported by every sme_host file.
package sme_pkg;

    localparam int STR_MAX_DEF = 32;
    localparam int PAT_MAX_DEF = 8;

    // Physical register-file depths; STR_MAX/PAT_MAX may only shrink them.
    localparam int STR_DEPTH = 32;
    localparam int PAT_DEPTH = 8;

    localparam logic [7:0] CH_CARET  = 8'h5E;
    localparam logic [7:0] CH_DOLLAR = 8'h24;
    localparam logic [7:0] CH_DOT    = 8'h2E;
    localparam logic [7:0] CH_STAR   = 8'h2A;
    localparam logic [7:0] CH_SPACE  = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND_STR = 3'd1,
        ST_SEND_PAT = 3'd2,
        ST_WAIT     = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

endpackage

// File: rtl/sme_host_buf.sv
// String and pattern character buffers: one write port, one read port.
// Read is combinational; a write lands on the clock edge.
// No backpressure; writes to addresses beyond the configured depth are dropped.
module sme_host_buf
    import sme_pkg::*;
#(
    parameter int STR_MAX = STR_MAX_DEF,
    parameter int PAT_MAX = PAT_MAX_DEF
) (
    input  logic       clk,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       rd_sel,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_data
);

    logic [7:0] str_mem [STR_DEPTH];
    logic [7:0] pat_mem [PAT_DEPTH];

    // Contents are not reset; the host always writes before it sends.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            if (!wr_sel && (32'(wr_addr) < STR_MAX))
                str_mem[wr_addr] <= wr_data;
            if (wr_sel && (32'(wr_addr) < PAT_MAX))
                pat_mem[wr_addr[2:0]] <= wr_data;
        end
    end

    assign rd_data = rd_sel ? pat_mem[rd_addr[2:0]] : str_mem[rd_addr];

endmodule

// File: rtl/sme_host.sv
// Host sequencer for a string matcher: streams string then pattern characters, waits for result.
// Latency: first character the cycle after start; done one cycle after valid or after TIMEOUT_CYC WAIT cycles.
// No backpressure: start is ignored while busy, valid is ignored outside WAIT.
module sme_host
    import sme_pkg::*;
#(
    parameter int STR_MAX     = STR_MAX_DEF,
    parameter int PAT_MAX     = PAT_MAX_DEF,
    parameter int TIMEOUT_CYC = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic       wr_sel,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       start,
    input  logic [5:0] str_len,
    input  logic [3:0] pat_len,
    output logic [7:0] chardata,
    output logic       isstring,
    output logic       ispattern,
    input  logic       valid,
    input  logic       match,
    input  logic [4:0] match_index,
    output logic       busy,
    output logic       done,
    output logic       res_match,
    output logic [4:0] res_index,
    output logic       timeout
);

    state_t     state;
    logic [5:0] slen;
    logic [3:0] plen;
    logic [5:0] cnt;       // index of the next character to put on chardata
    logic [7:0] wcnt;      // WAIT cycles already spent
    logic       rd_sel;
    logic [4:0] rd_addr;
    logic [7:0] rd_data;
    logic [5:0] str_len_sat;
    logic [3:0] pat_len_sat;

    sme_host_buf #(
        .STR_MAX (STR_MAX),
        .PAT_MAX (PAT_MAX)
    ) u_buf (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_sel  (wr_sel),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_sel  (rd_sel),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

    // Lengths clamp to buffer depth; a zero pattern length is treated as one character.
    assign str_len_sat = (str_len > 6'(STR_MAX)) ? 6'(STR_MAX) : str_len;
    assign pat_len_sat = (pat_len > 4'(PAT_MAX)) ? 4'(PAT_MAX)
                       : ((pat_len == 4'd0) ? 4'd1 : pat_len);

    // Address the character that will be registered onto chardata at the next edge.
    always_comb begin
        rd_sel  = 1'b0;
        rd_addr = 5'd0;
        case (state)
            ST_IDLE: begin
                rd_sel  = (str_len == 6'd0);
                rd_addr = 5'd0;
            end
            ST_SEND_STR: begin
                if (cnt < slen) begin
                    rd_sel  = 1'b0;
                    rd_addr = 5'(cnt);
                end else begin
                    rd_sel  = 1'b1;
                    rd_addr = 5'd0;
                end
            end
            ST_SEND_PAT: begin
                rd_sel  = 1'b1;
                rd_addr = 5'(cnt);
            end
            default: begin
                rd_sel  = 1'b0;
                rd_addr = 5'd0;
            end
        endcase
    end

    // Job sequencer; every output is registered here.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            slen      <= 6'd0;
            plen      <= 4'd0;
            cnt       <= 6'd0;
            wcnt      <= 8'd0;
            chardata  <= 8'd0;
            isstring  <= 1'b0;
            ispattern <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            res_match <= 1'b0;
            res_index <= 5'd0;
            timeout   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        slen     <= str_len_sat;
                        plen     <= pat_len_sat;
                        busy     <= 1'b1;
                        chardata <= rd_data;
                        cnt      <= 6'd1;
                        if (str_len != 6'd0) begin
                            state    <= ST_SEND_STR;
                            isstring <= 1'b1;
                        end else begin
                            state     <= ST_SEND_PAT;
                            ispattern <= 1'b1;
                        end
                    end
                end
                ST_SEND_STR: begin
                    chardata <= rd_data;
                    if (cnt < slen) begin
                        cnt <= cnt + 6'd1;
                    end else begin
                        state     <= ST_SEND_PAT;
                        isstring  <= 1'b0;
                        ispattern <= 1'b1;
                        cnt       <= 6'd1;
                    end
                end
                ST_SEND_PAT: begin
                    if (cnt < {2'b00, plen}) begin
                        chardata <= rd_data;
                        cnt      <= cnt + 6'd1;
                    end else begin
                        state     <= ST_WAIT;
                        chardata  <= 8'd0;
                        ispattern <= 1'b0;
                        wcnt      <= 8'd0;
                    end
                end
                ST_WAIT: begin
                    if (valid) begin
                        res_match <= match;
                        res_index <= match_index;
                        timeout   <= 1'b0;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else if ((wcnt + 8'd1) == 8'(TIMEOUT_CYC)) begin
                        res_match <= 1'b0;
                        res_index <= 5'd0;
                        timeout   <= 1'b1;
                        done      <= 1'b1;
                        state     <= ST_DONE;
                    end else begin
                        wcnt <= wcnt + 8'd1;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sme_host.sv
// Randomized bench for sme_host against a buffer/stream reference model.
// Inputs driven and outputs sampled on the falling clock edge.
// Matcher side responds after a chosen number of WAIT cycles or never.
module tb_sme_host;

    localparam int TO = 10;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic       wr_sel;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       start;
    logic [5:0] str_len;
    logic [3:0] pat_len;
    logic [7:0] chardata;
    logic       isstring;
    logic       ispattern;
    logic       valid;
    logic       match;
    logic [4:0] match_index;
    logic       busy;
    logic       done;
    logic       res_match;
    logic [4:0] res_index;
    logic       timeout;

    logic [7:0] str_m [32];
    logic [7:0] pat_m [8];

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    sme_host #(
        .STR_MAX     (32),
        .PAT_MAX     (8),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_sel      (wr_sel),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .start       (start),
        .str_len     (str_len),
        .pat_len     (pat_len),
        .chardata    (chardata),
        .isstring    (isstring),
        .ispattern   (ispattern),
        .valid       (valid),
        .match       (match),
        .match_index (match_index),
        .busy        (busy),
        .done        (done),
        .res_match   (res_match),
        .res_index   (res_index),
        .timeout     (timeout)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Drive one write for the next edge and mirror it into the model buffers.
    task automatic drive_write(input bit en, input bit sel, input int a, input int d);
        wr_en   = en;
        wr_sel  = sel;
        wr_addr = 5'(a);
        wr_data = 8'(d);
        if (en) begin
            if (!sel && a < 32) str_m[a] = 8'(d);
            if (sel && a < 8)   pat_m[a] = 8'(d);
        end
    endtask

    task automatic rand_write(input bit allow);
        if (allow && $urandom_range(0, 2) == 0)
            drive_write(1'b1, 1'($urandom_range(0, 1)), $urandom_range(0, 31), $urandom_range(32, 126));
        else
            drive_write(1'b0, 1'b0, 0, 0);
    endtask

    task automatic write_buf(input bit sel, input int a, input int d);
        @(negedge clk);
        drive_write(1'b1, sel, a, d);
        @(negedge clk);
        drive_write(1'b0, 1'b0, 0, 0);
    endtask

    // One job: sl/pl raw lengths, k = WAIT cycle in which valid is given (>= TO means never).
    task automatic run_job(input int sl, input int pl, input int k, input bit m, input int idx, input bit noise);
        int slen;
        int plen;
        int len;
        int exp_j;
        int got_j;
        logic       exp_s;
        logic       exp_p;
        logic [7:0] exp_c;
        slen  = (sl > 32) ? 32 : sl;
        plen  = (pl > 8) ? 8 : pl;
        len   = slen + plen;
        got_j = 0;
        @(negedge clk);
        exp_s = (slen > 0);
        exp_p = (slen == 0);
        exp_c = (slen > 0) ? str_m[0] : pat_m[0];
        start   = 1'b1;
        str_len = 6'(sl);
        pat_len = 4'(pl);
        rand_write(noise);
        for (int p = 1; p <= len; p++) begin
            @(negedge clk);
            chk("isstring", 32'(isstring), 32'(exp_s));
            chk("ispattern", 32'(ispattern), 32'(exp_p));
            chk("chardata", 32'(chardata), 32'(exp_c));
            chk("busy_send", 32'(busy), 32'd1);
            chk("done_send", 32'(done), 32'd0);
            if (p < len) begin
                exp_s = (p < slen);
                exp_p = (p >= slen);
                exp_c = (p < slen) ? str_m[p] : pat_m[p - slen];
            end
            start       = noise && ($urandom_range(0, 3) == 0);
            str_len     = 6'($urandom_range(0, 63));
            pat_len     = 4'($urandom_range(1, 15));
            valid       = noise && ($urandom_range(0, 3) == 0);
            match       = 1'($urandom_range(0, 1));
            match_index = 5'($urandom_range(0, 31));
            rand_write(noise);
        end
        for (int j = 1; j <= 40; j++) begin
            @(negedge clk);
            start = 1'b0;
            drive_write(1'b0, 1'b0, 0, 0);
            if (j == 1) begin
                chk("wait_chardata", 32'(chardata), 32'd0);
                chk("wait_flags", 32'({isstring, ispattern}), 32'd0);
                chk("wait_done", 32'(done), 32'd0);
            end
            if (done) begin
                got_j = j;
                break;
            end
            valid       = (j == k + 1);
            match       = m;
            match_index = 5'(idx);
        end
        valid = 1'b0;
        exp_j = (k < TO) ? k + 2 : TO + 1;
        chk("done_cycle", 32'(got_j), 32'(exp_j));
        if (got_j != 0) begin
            chk("res_match", 32'(res_match), (k < TO) ? 32'(m) : 32'd0);
            chk("res_index", 32'(res_index), (k < TO) ? 32'(idx) : 32'd0);
            chk("timeout", 32'(timeout), (k < TO) ? 32'd0 : 32'd1);
            chk("busy_done", 32'(busy), 32'd1);
        end
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("res_hold", 32'(res_index), (k < TO) ? 32'(idx) : 32'd0);
    endtask

    initial begin
        int n_done;
        reset = 1'b1;
        start = 1'b0;
        str_len = 6'd0;
        pat_len = 4'd1;
        valid = 1'b0;
        match = 1'b0;
        match_index = 5'd0;
        drive_write(1'b0, 1'b0, 0, 0);
        repeat (3) @(negedge clk);
        chk("rst_out", 32'({chardata, isstring, ispattern, busy, done}), 32'd0);
        chk("rst_res", 32'({res_match, res_index, timeout}), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 32; i++) write_buf(1'b0, i, $urandom_range(32, 126));
        for (int i = 0; i < 8; i++)  write_buf(1'b1, i, $urandom_range(32, 126));

        // "ab cd" against "cd", matcher reports a hit at index 3
        write_buf(1'b0, 0, 8'h61);
        write_buf(1'b0, 1, 8'h62);
        write_buf(1'b0, 2, 8'h20);
        write_buf(1'b0, 3, 8'h63);
        write_buf(1'b0, 4, 8'h64);
        write_buf(1'b1, 0, 8'h63);
        write_buf(1'b1, 1, 8'h64);
        write_buf(1'b1, 9, 8'h7A);   // beyond pattern depth, dropped
        run_job(5, 2, 0, 1'b1, 3, 1'b0);

        run_job(0, 3, 2, 1'b0, 7, 1'b0);      // reuse string: pattern only
        run_job(4, 2, 20, 1'b1, 5, 1'b0);     // no valid: timeout
        run_job(3, 1, TO - 1, 1'b1, 9, 1'b0); // valid in the last WAIT cycle wins
        run_job(40, 12, 1, 1'b1, 17, 1'b0);   // saturated lengths
        run_job(6, 4, 3, 1'b1, 2, 1'b1);      // noise: spurious start/valid, writes

        // reset in the middle of a string send
        @(negedge clk);
        start = 1'b1;
        str_len = 6'd20;
        pat_len = 4'd2;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_isstring", 32'(isstring), 32'd1);
        #2 reset = 1'b1;
        #1;
        chk("rst_isstring", 32'(isstring), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_chardata", 32'(chardata), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        n_done = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) n_done++;
        end
        chk("no_done_after_rst", 32'(n_done), 32'd0);

        for (int i = 0; i < 32; i++) write_buf(1'b0, i, $urandom_range(32, 126));
        for (int i = 0; i < 8; i++)  write_buf(1'b1, i, $urandom_range(32, 126));

        repeat (25)
            run_job($urandom_range(0, 40), $urandom_range(1, 15), $urandom_range(0, 14),
                    1'($urandom_range(0, 1)), $urandom_range(0, 31), 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule

// File: doc/sme_host.md
SME_HOST -- requirements
Module: sme_host

Interface
REQ-001 Parameter STR_MAX, 32, string buffer depth in characters.
REQ-002 Parameter PAT_MAX, 8, pattern buffer depth in characters.
REQ-003 Parameter TIMEOUT_CYC, 255, maximum WAIT cycles before timeout; range 1..255.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 wr_en  input  1  buffer write strobe.
REQ-007 wr_sel  input  1  0 = string buffer, 1 = pattern buffer.
REQ-008 wr_addr  input  5  buffer write address.
REQ-009 wr_data  input  8  ASCII character to write.
REQ-010 start  input  1  one-cycle request to run one match job.
REQ-011 str_len  input  6  string length 0..32; 0 = reuse the previously sent string.
REQ-012 pat_len  input  4  pattern length 1..8.
REQ-013 chardata  output  8  character to the matcher.
REQ-014 isstring  output  1  chardata is a string character.
REQ-015 ispattern  output  1  chardata is a pattern character.
REQ-016 valid  input  1  matcher result strobe.
REQ-017 match  input  1  matcher result flag.
REQ-018 match_index  input  5  matcher result index.
REQ-019 busy  output  1  job in progress.
REQ-020 done  output  1  one-cycle job-complete pulse.
REQ-021 res_match, res_index  output  1/5  captured result, held until next done.
REQ-022 timeout  output  1  set with done when no valid arrived; held until next done.

Function
REQ-023 FSM states IDLE, SEND_STR, SEND_PAT, WAIT, DONE.
REQ-024 IDLE: start with str_len!=0 -> SEND_STR; with str_len==0 -> SEND_PAT; start ignored in all other states.
REQ-025 str_len and pat_len latched on the accepted start; values above STR_MAX/PAT_MAX saturate to the maximum.
REQ-026 chardata, isstring and ispattern registered; first character appears the cycle after start is accepted.
REQ-027 SEND_STR: one string character per cycle at addresses 0..len-1, isstring=1, contiguous, no gaps.
REQ-028 SEND_PAT follows SEND_STR with no idle cycle: ispattern=1 for exactly pat_len cycles; isstring and ispattern never both 1.
REQ-029 Outside send states: isstring=ispattern=0, chardata=0.
REQ-030 WAIT: 8-bit counter cleared on entry, increments each cycle; valid=1 -> capture match/match_index -> DONE; counter==TIMEOUT_CYC -> timeout=1, res_match=0, res_index=0 -> DONE.
REQ-031 DONE: done=1 for one cycle, then IDLE; busy=1 from the cycle after start through DONE inclusive.
REQ-032 valid outside WAIT ignored; valid and timeout in the same cycle: valid wins.
REQ-033 Writes are accepted in any state; a write to the address being sent in the same cycle sends the old value.
REQ-034 wr_addr above buffer depth-1 ignored (pattern buffer uses wr_addr[2:0] only when wr_addr<8).

Reset
REQ-035 reset asynchronously forces IDLE, clears counters and all outputs to 0; buffer contents undefined.
REQ-036 reset mid-job abandons it without a done pulse; the next start after reset is a normal job.

Structure
REQ-037 Shared package sme_pkg holds the state encoding, ASCII constants (^ 8'h5E, $ 8'h24, . 8'h2E, * 8'h2A, space 8'h20) and STR_MAX/PAT_MAX defaults.
REQ-038 One sub-module sme_host_buf: dual 8-bit register file (32+8 entries), one write port, one combinational read port.

Verification
REQ-039 Load "ab cd" into string, "cd" into pattern, start(5,2) -> isstring 5 cycles then ispattern 2 cycles back-to-back; matcher valid,match=1,index=3 -> done, res_match=1, res_index=3.
REQ-040 start with str_len=0, pat_len=3 -> no isstring cycle, ispattern exactly 3 cycles.
REQ-041 No valid in WAIT, TIMEOUT_CYC=10 -> done with timeout=1 after 10 WAIT cycles, res_match=0.
REQ-042 start asserted during SEND_PAT -> ignored; only one done pulse.
REQ-043 reset asserted during SEND_STR -> isstring drops immediately, no done, busy=0.
REQ-044 start(40,12) -> exactly 32 string and 8 pattern cycles.
